// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: hh:mm:ss timekeeping, alarm registers, button-driven
// set-mode FSM and alarm ring/snooze sequencing for the 6-digit BCD clock.
//
// Optional feature macro: SNOOZE_EN
//   defined   -> btn_snooze silences an active ring for SNOOZE_SECS, then re-rings
//   undefined -> btn_snooze ignored, no snooze counter; a ring ends only by
//                RING_SECS expiry or alarm_en=0
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal timekeeping, time shown, inc ignored
// ST_SET_HR   | time frozen, inc bumps time hours, hours blink
// ST_SET_MIN  | time frozen, inc bumps time minutes, minutes blink
// ST_SET_AHR  | time runs, alarm shown, inc bumps alarm hours
// ST_SET_AMIN | time runs, alarm shown, inc bumps alarm minutes

module clock_mode_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned ALM_RST_HR  = 6
) (
  input  logic       clk_1hz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       alarm_en,
  output logic [3:0] disp_hours_M,
  output logic [3:0] disp_hours_L,
  output logic [3:0] disp_mins_M,
  output logic [3:0] disp_mins_L,
  output logic [3:0] disp_secs_M,
  output logic [3:0] disp_secs_L,
  output logic [5:0] blink_mask,
  output logic [2:0] mode,
  output logic       alarm_ring
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HR   = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_AHR  = 3'd3,
    ST_SET_AMIN = 3'd4
  } state_t;

  localparam logic [7:0] ALM_RST_BCD = {4'(ALM_RST_HR / 10), 4'(ALM_RST_HR % 10)};
  localparam logic [7:0] RING_LOAD   = 8'(RING_SECS);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS);

  // Two-digit BCD increment wrapping 23 -> 00.
  function automatic logic [7:0] bcd_inc_hr(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD increment wrapping 59 -> 00.
  function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t     state_q, state_nxt;
  logic       mode_q, inc_q;
  logic       mode_press, inc_press;
  logic [7:0] hr_q, mn_q, sc_q;
  logic [7:0] al_hr_q, al_mn_q;
  logic [7:0] ring_cnt_q;
  logic       ring_q;
  logic       alarm_match;
  logic [23:0] disp_bcd;

  // A press is a 0->1 transition; mode wins over a simultaneous inc.
  assign mode_press  = btn_mode & ~mode_q;
  assign inc_press   = btn_inc & ~inc_q & ~mode_press;
  assign alarm_match = (hr_q == al_hr_q) && (mn_q == al_mn_q) && (sc_q == 8'h00);

  // Button history for edge detection.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
    end
  end

  // Mode FSM state register.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset)
      state_q <= ST_RUN;
    else
      state_q <= state_nxt;
  end

  // Mode FSM next state: each mode press steps to the next edit field.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RUN:      if (mode_press) state_nxt = ST_SET_HR;
      ST_SET_HR:   if (mode_press) state_nxt = ST_SET_MIN;
      ST_SET_MIN:  if (mode_press) state_nxt = ST_SET_AHR;
      ST_SET_AHR:  if (mode_press) state_nxt = ST_SET_AMIN;
      ST_SET_AMIN: if (mode_press) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // Time register: runs outside the time-edit states, edited while frozen.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      hr_q <= 8'h00;
      mn_q <= 8'h00;
      sc_q <= 8'h00;
    end else begin
      case (state_q)
        ST_RUN, ST_SET_AHR, ST_SET_AMIN: begin
          sc_q <= bcd_inc_60(sc_q);
          if (sc_q == 8'h59) begin
            mn_q <= bcd_inc_60(mn_q);
            if (mn_q == 8'h59)
              hr_q <= bcd_inc_hr(hr_q);
          end
        end
        ST_SET_HR: begin
          if (inc_press)
            hr_q <= bcd_inc_hr(hr_q);
        end
        ST_SET_MIN: begin
          // Leaving minute edit restarts the minute from :00.
          if (mode_press)
            sc_q <= 8'h00;
          else if (inc_press)
            mn_q <= bcd_inc_60(mn_q);
        end
        default: ;
      endcase
    end
  end

  // Alarm time register, edited in the alarm set states.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      al_hr_q <= ALM_RST_BCD;
      al_mn_q <= 8'h00;
    end else if (inc_press) begin
      if (state_q == ST_SET_AHR)
        al_hr_q <= bcd_inc_hr(al_hr_q);
      else if (state_q == ST_SET_AMIN)
        al_mn_q <= bcd_inc_60(al_mn_q);
    end
  end

`ifdef SNOOZE_EN
  logic       snooze_q;
  logic       snooze_press;
  logic [9:0] snz_cnt_q;

  assign snooze_press = btn_snooze & ~snooze_q;

  // Snooze button history.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset)
      snooze_q <= 1'b0;
    else
      snooze_q <= btn_snooze;
  end

  // Ring/snooze sequencer; alarm_en low clears everything first.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 10'd0;
    end else if (!alarm_en) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 10'd0;
    end else if (ring_q) begin
      if (snooze_press) begin
        ring_q     <= 1'b0;
        ring_cnt_q <= 8'd0;
        snz_cnt_q  <= SNOOZE_LOAD;
      end else if (ring_cnt_q == 8'd1) begin
        ring_q     <= 1'b0;
        ring_cnt_q <= 8'd0;
      end else begin
        ring_cnt_q <= ring_cnt_q - 8'd1;
      end
    end else if (snz_cnt_q != 10'd0) begin
      snz_cnt_q <= snz_cnt_q - 10'd1;
      if (snz_cnt_q == 10'd1) begin
        ring_q     <= 1'b1;
        ring_cnt_q <= RING_LOAD;
      end
    end else if (alarm_match) begin
      ring_q     <= 1'b1;
      ring_cnt_q <= RING_LOAD;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = &{btn_snooze, SNOOZE_LOAD};

  // Ring sequencer; alarm_en low clears the ring first.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
    end else if (!alarm_en) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
    end else if (ring_q) begin
      if (ring_cnt_q == 8'd1) begin
        ring_q     <= 1'b0;
        ring_cnt_q <= 8'd0;
      end else begin
        ring_cnt_q <= ring_cnt_q - 8'd1;
      end
    end else if (alarm_match) begin
      ring_q     <= 1'b1;
      ring_cnt_q <= RING_LOAD;
    end
  end
`endif

  // Display source and blink mask follow the current edit state.
  always_comb begin
    disp_bcd   = {hr_q, mn_q, sc_q};
    blink_mask = 6'b000000;
    case (state_q)
      ST_SET_HR:   blink_mask = 6'b110000;
      ST_SET_MIN:  blink_mask = 6'b001100;
      ST_SET_AHR: begin
        disp_bcd   = {al_hr_q, al_mn_q, 8'h00};
        blink_mask = 6'b110000;
      end
      ST_SET_AMIN: begin
        disp_bcd   = {al_hr_q, al_mn_q, 8'h00};
        blink_mask = 6'b001100;
      end
      default: ;
    endcase
  end

  assign {disp_hours_M, disp_hours_L, disp_mins_M, disp_mins_L, disp_secs_M, disp_secs_L} = disp_bcd;
  assign mode       = state_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: set mode, wrap, alarm ring, snooze,
// alarm_en drop and async reset mid-ring.
module tb_clock_mode_ctrl;

  logic       clk_1hz = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_snooze, alarm_en;
  logic [3:0] disp_hours_M, disp_hours_L, disp_mins_M, disp_mins_L, disp_secs_M, disp_secs_L;
  logic [5:0] blink_mask;
  logic [2:0] mode;
  logic       alarm_ring;
  logic [23:0] disp;

  int checks = 0;
  int errors = 0;

  clock_mode_ctrl dut (
    .clk_1hz      (clk_1hz),
    .reset        (reset),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_snooze   (btn_snooze),
    .alarm_en     (alarm_en),
    .disp_hours_M (disp_hours_M),
    .disp_hours_L (disp_hours_L),
    .disp_mins_M  (disp_mins_M),
    .disp_mins_L  (disp_mins_L),
    .disp_secs_M  (disp_secs_M),
    .disp_secs_L  (disp_secs_L),
    .blink_mask   (blink_mask),
    .mode         (mode),
    .alarm_ring   (alarm_ring)
  );

  assign disp = {disp_hours_M, disp_hours_L, disp_mins_M, disp_mins_L, disp_secs_M, disp_secs_L};

  always #5 clk_1hz = ~clk_1hz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_1hz);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(1);
    btn_mode = 1'b0; step(1);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; step(1);
    btn_inc = 1'b0; step(1);
  endtask

  task automatic apply_reset();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0; alarm_en = 1'b0;
    reset = 1'b1; #3;
    reset = 1'b0;
  endtask

  // Leaves the clock in RUN at hh:mm:05 starting from reset.
  task automatic set_time(input int h, input int m);
    press_mode();
    repeat (h) press_inc();
    press_mode();
    repeat (m) press_inc();
    repeat (3) press_mode();
  endtask

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0; alarm_en = 1'b0;
    #12;
    check("rst_disp", disp, 24'h000000);
    check("rst_mode", mode, 3'd0);
    check("rst_blink", blink_mask, 6'b000000);
    check("rst_ring", alarm_ring, 1'b0);
    reset = 1'b0;

    // Set mode walk-through
    step(3);
    check("run_3s", disp, 24'h000003);
    press_mode();
    check("sethr_mode", mode, 3'd1);
    check("sethr_blink", blink_mask, 6'b110000);
    check("sethr_frozen", disp, 24'h000004);
    repeat (25) press_inc();
    check("hr_inc25", disp, 24'h010004);
    btn_inc = 1'b1; step(3);
    btn_inc = 1'b0; step(1);
    check("hr_held_once", disp, 24'h020004);
    press_mode();
    check("setmin_mode", mode, 3'd2);
    check("setmin_blink", blink_mask, 6'b001100);
    repeat (61) press_inc();
    check("min_inc61", disp, 24'h020104);
    press_mode();
    check("setahr_mode", mode, 3'd3);
    check("setahr_disp", disp, 24'h060000);
    check("setahr_blink", blink_mask, 6'b110000);
    btn_mode = 1'b1; btn_inc = 1'b1; step(1);
    btn_mode = 1'b0; btn_inc = 1'b0; step(1);
    check("simul_mode", mode, 3'd4);
    check("simul_inc_dropped", disp, 24'h060000);
    check("setamin_blink", blink_mask, 6'b001100);
    press_mode();
    check("back_run_mode", mode, 3'd0);
    check("back_run_blink", blink_mask, 6'b000000);
    check("back_run_disp", disp, 24'h020105);
    step(1);
    check("run_resumes", disp, 24'h020106);

    // Midnight wrap
    apply_reset();
    set_time(23, 59);
    check("wrap_setup", disp, 24'h235905);
    step(54);
    check("wrap_235959", disp, 24'h235959);
    step(1);
    check("wrap_000000", disp, 24'h000000);
    step(1);
    check("wrap_000001", disp, 24'h000001);

    // Default alarm ring duration
    apply_reset();
    alarm_en = 1'b1;
    set_time(5, 59);
    step(54);
    check("alm_pre_disp", disp, 24'h055959);
    check("alm_pre_ring", alarm_ring, 1'b0);
    step(1);
    check("alm_match_disp", disp, 24'h060000);
    check("alm_match_ring", alarm_ring, 1'b0);
    step(1);
    check("alm_rise", alarm_ring, 1'b1);
    step(59);
    check("alm_last_high", alarm_ring, 1'b1);
    step(1);
    check("alm_drop", alarm_ring, 1'b0);

    // Snooze
    apply_reset();
    alarm_en = 1'b1;
    set_time(5, 59);
    step(56);
    check("snz_rise", alarm_ring, 1'b1);
    step(10);
    btn_snooze = 1'b1; step(1);
    btn_snooze = 1'b0;
`ifdef SNOOZE_EN
    check("snz_silenced", alarm_ring, 1'b0);
    step(299);
    check("snz_still_quiet", alarm_ring, 1'b0);
    step(1);
    check("snz_rering", alarm_ring, 1'b1);
    step(59);
    check("snz_rering_last", alarm_ring, 1'b1);
    step(1);
    check("snz_rering_drop", alarm_ring, 1'b0);
`else
    check("snz_ignored", alarm_ring, 1'b1);
    step(48);
    check("snz_ign_last", alarm_ring, 1'b1);
    step(1);
    check("snz_ign_drop", alarm_ring, 1'b0);
`endif
    btn_snooze = 1'b1; step(1);
    btn_snooze = 1'b0; step(2);
    check("snz_idle_press", alarm_ring, 1'b0);

    // alarm_en drop mid-ring
    apply_reset();
    alarm_en = 1'b1;
    set_time(5, 59);
    step(56);
    check("en_rise", alarm_ring, 1'b1);
    step(5);
    alarm_en = 1'b0; step(1);
    check("en_drop", alarm_ring, 1'b0);
    alarm_en = 1'b1; step(1);
    check("en_reenable", alarm_ring, 1'b0);
    step(30);
    check("en_no_rering", alarm_ring, 1'b0);
    check("en_time", disp, 24'h060038);

    // Edit during ring, then async reset in SET_AMIN
    apply_reset();
    alarm_en = 1'b1;
    set_time(5, 59);
    step(56);
    check("ar_rise", alarm_ring, 1'b1);
    repeat (3) press_mode();
    check("ar_ahr_mode", mode, 3'd3);
    press_inc();
    check("ar_ahr_inc", disp, 24'h070000);
    press_mode();
    press_inc();
    check("ar_amin_disp", disp, 24'h070100);
    check("ar_amin_mode", mode, 3'd4);
    check("ar_edit_keeps_ring", alarm_ring, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_disp", disp, 24'h000000);
    check("ar_mode", mode, 3'd0);
    check("ar_blink", blink_mask, 6'b000000);
    check("ar_ring", alarm_ring, 1'b0);
    reset = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
